alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, fully pipelined successor to the single-issue stage ALU. It takes one action per cycle from sub_action with two operands, decodes an 8-bit opcode, and computes a result plus status flags. The result is delivered to PHV re-assembly after a fixed, configurable latency, with data and valid aligned. The block sits in each RMT action stage, one instance per container lane.

## Interface
- STAGE_ID, 0, stage index, informational only
- ACTION_LEN, 64, action word width; opcode is action_in[ACTION_LEN-1 -: 8]
- DATA_WIDTH, 48, operand/result width (8..64)
- LATENCY, 2, cycles from action_valid to container_out_valid (1..8)
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- action_in  in  ACTION_LEN  action word
- action_valid  in  1  qualifies action_in and operands, sampled every cycle
- operand_1_in  in  DATA_WIDTH  first operand (header field)
- operand_2_in  in  DATA_WIDTH  second operand (header field or immediate, selected upstream)
- container_out  out  DATA_WIDTH  result
- container_out_valid  out  1  one-cycle strobe per accepted action
- flags_out  out  3  {overflow, carry_borrow, zero}, aligned with container_out

## Operation
- No backpressure; an action is accepted on every cycle in which action_valid=1, including back-to-back.
- Opcode decode:
  - 0x01, 0x09: add
  - 0x02, 0x0A: sub (op1-op2)
  - 0x03: and
  - 0x04: or
  - 0x05: xor
  - 0x06: shl op1 by op2[$clog2(DATA_WIDTH)-1:0]
  - 0x07: logical shr op1 by the same amount
  - 0x0E: set (result=op2)
  - any other opcode: pass op1
- Arithmetic runs at DATA_WIDTH+1 bits.
  - carry_borrow = bit DATA_WIDTH (add carry-out, or sub borrow when op1<op2 unsigned).
  - overflow = signed two's-complement overflow for add/sub; 0 for all other ops.
  - zero = (result==0) for all ops.
- Shift amounts >= DATA_WIDTH yield 0.
- Results and flags travel through a LATENCY-deep register pipeline together with a valid bit. Ordering is strictly preserved.
- container_out and flags_out hold their last valid value while container_out_valid=0. They change only on cycles when a valid entry emerges.

## Timing
- Action accepted at edge N produces container_out_valid=1 in the cycle after edge N+LATENCY-1. LATENCY=1 means the output is registered directly from the decode.
- Throughput is 1 result/cycle; N consecutive valid inputs yield N consecutive valid outputs.
- Reset (rst=1 at an edge):
  - clears all pipeline valid bits
  - container_out=0, flags_out=0, container_out_valid=0
- In-flight actions are discarded on reset and never emerge. Inputs presented while rst=1 are ignored.
- The first action is accepted at the first edge with rst=0.

## Configuration
- ALU_SAT_EN defined:
  - add saturates to all-ones on unsigned carry.
  - sub saturates to 0 on borrow.
  - carry_borrow still reports the saturation event; overflow is unchanged.
- ALU_SAT_EN undefined: add/sub wrap modulo 2^DATA_WIDTH.

## Structure
- Package alu_pkg:
  - opcode localparams (OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SET)
  - flag bit indices
  - OPCODE_WIDTH=8
- Sub-module alu_delay_line: parametrised valid+payload shift register, depth LATENCY-1, synchronous active-high clear of valid bits only. The top module holds the decode/compute stage.

## Test plan
- Single add, DATA_WIDTH=48, op1=5, op2=7, opcode 0x01 -> 12 after LATENCY cycles; flags=000; valid exactly one cycle.
- Sub, op1=3, op2=5 -> wrap 0xFFFF_FFFF_FFFE with carry_borrow=1. With ALU_SAT_EN, result 0 and carry_borrow=1.
- Back-to-back: 4 actions on consecutive cycles (add, xor 0xFF^0x0F, shl 1 by 4, opcode 0x55 op1=9) -> 4 consecutive valid outputs 12-type results, 0xF0, 0x10, 9, in order.
- Signed overflow: add 0x7FFF_FFFF_FFFF+1 -> 0x8000_0000_0000, overflow=1, carry=0. Add all-ones+1 -> 0, zero=1, carry=1.
- Reset mid-flight: issue 2 actions, assert rst one cycle later -> no valid strobe, outputs 0. The next action after rst drops produces a normal result.
- LATENCY sweep 1, 2, 5: measure the action_valid-to-container_out_valid distance equals LATENCY. container_out holds its value between strobes.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, flag bit positions and decode helper for alu_pipe.
// Build option: define ALU_SAT_EN for saturating add/sub.
package alu_pkg;

   localparam int OPCODE_WIDTH = 8;
   localparam int FLAG_WIDTH   = 3;

   localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 8'h01;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 8'h02;
   localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 8'h03;
   localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 8'h04;
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = 8'h05;
   localparam logic [OPCODE_WIDTH-1:0] OP_SHL  = 8'h06;
   localparam logic [OPCODE_WIDTH-1:0] OP_SHR  = 8'h07;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 8'h09;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 8'h0A;
   localparam logic [OPCODE_WIDTH-1:0] OP_SET  = 8'h0E;

   // flags_out = {overflow, carry_borrow, zero}
   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_OVF   = 2;

   typedef enum logic [3:0] {
      FN_PASS,
      FN_ADD,
      FN_SUB,
      FN_AND,
      FN_OR,
      FN_XOR,
      FN_SHL,
      FN_SHR,
      FN_SET
   } alu_fn_e;

   function automatic alu_fn_e decode_op(
      input logic [OPCODE_WIDTH-1:0] op
   );
      alu_fn_e fn;
      fn = FN_PASS;
      unique case (1'b1)
         (op == OP_ADD) || (op == OP_ADDI): fn = FN_ADD;
         (op == OP_SUB) || (op == OP_SUBI): fn = FN_SUB;
         (op == OP_AND): fn = FN_AND;
         (op == OP_OR):  fn = FN_OR;
         (op == OP_XOR): fn = FN_XOR;
         (op == OP_SHL): fn = FN_SHL;
         (op == OP_SHR): fn = FN_SHR;
         (op == OP_SET): fn = FN_SET;
         default:        fn = FN_PASS;
      endcase
      return fn;
   endfunction

endpackage

// File: rtl/alu_delay_line.sv
// alu_delay_line: valid+payload shift register of configurable depth.
// clr drops valid bits only; payload bits are don't-care when invalid.
module alu_delay_line
   import alu_pkg::*;
#(
   parameter int WIDTH = 51,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_ctl;
         assign unused_ctl = clk ^ clr;
         assign out_valid  = in_valid;
         assign out_data   = in_data;
      end else begin : g_shift
         logic [DEPTH-1:0] valid_q;
         logic [DEPTH-1:0] valid_d;
         logic [WIDTH-1:0] data_q [DEPTH];
         logic [WIDTH-1:0] data_d [DEPTH];

         always_comb begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            for (int i = 1; i < DEPTH; i++) begin
               valid_d[i] = valid_q[i-1];
               data_d[i]  = data_q[i-1];
            end
            if (clr) begin
               valid_d = '0;
            end
         end

         always_ff @(posedge clk) begin
            valid_q <= valid_d;
            data_q  <= data_d;
         end

         assign out_valid = valid_q[DEPTH-1];
         assign out_data  = data_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined action-stage ALU, one result per cycle.
// Build option: ALU_SAT_EN makes add/sub saturate instead of wrap.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int STAGE_ID   = 0,
   parameter int ACTION_LEN = 64,
   parameter int DATA_WIDTH = 48,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ACTION_LEN-1:0] action_in,
   input  logic                  action_valid,
   input  logic [DATA_WIDTH-1:0] operand_1_in,
   input  logic [DATA_WIDTH-1:0] operand_2_in,
   output logic [DATA_WIDTH-1:0] container_out,
   output logic                  container_out_valid,
   output logic [2:0]            flags_out
);

   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int PW  = DATA_WIDTH + FLAG_WIDTH;
   localparam logic [7:0] STAGE_TAG = 8'(STAGE_ID);

   logic [OPCODE_WIDTH-1:0] opcode;
   alu_fn_e                 fn;
   logic [DATA_WIDTH:0]     sum;
   logic [DATA_WIDTH:0]     diff;
   logic [SHW-1:0]          shamt;
   logic                    shift_oob;
   logic                    a_msb;
   logic                    b_msb;
   logic [DATA_WIDTH-1:0]   res;
   logic                    carry;
   logic                    ovf;
   logic [FLAG_WIDTH-1:0]   flags;
   logic                    unused_bits;

   assign opcode = action_in[ACTION_LEN-1 -: OPCODE_WIDTH];
   assign fn     = decode_op(opcode);
   assign sum    = {1'b0, operand_1_in} + {1'b0, operand_2_in};
   assign diff   = {1'b0, operand_1_in} - {1'b0, operand_2_in};
   assign shamt  = operand_2_in[SHW-1:0];
   assign a_msb  = operand_1_in[DATA_WIDTH-1];
   assign b_msb  = operand_2_in[DATA_WIDTH-1];

   assign shift_oob = 32'(shamt) >= DATA_WIDTH;

   assign unused_bits = ^{action_in[ACTION_LEN-OPCODE_WIDTH-1:0],
                          STAGE_TAG};

   always_comb begin
      res   = operand_1_in;
      carry = 1'b0;
      ovf   = 1'b0;
      case (fn)
         FN_ADD: begin
            res   = sum[DATA_WIDTH-1:0];
            carry = sum[DATA_WIDTH];
            ovf   = (a_msb == b_msb) &&
                    (sum[DATA_WIDTH-1] != a_msb);
`ifdef ALU_SAT_EN
            if (carry) begin
               res = '1;
            end
`endif
         end
         FN_SUB: begin
            res   = diff[DATA_WIDTH-1:0];
            carry = diff[DATA_WIDTH];
            ovf   = (a_msb != b_msb) &&
                    (diff[DATA_WIDTH-1] != a_msb);
`ifdef ALU_SAT_EN
            if (carry) begin
               res = '0;
            end
`endif
         end
         FN_AND: res = operand_1_in & operand_2_in;
         FN_OR:  res = operand_1_in | operand_2_in;
         FN_XOR: res = operand_1_in ^ operand_2_in;
         FN_SHL: res = shift_oob ? '0 : operand_1_in << shamt;
         FN_SHR: res = shift_oob ? '0 : operand_1_in >> shamt;
         FN_SET: res = operand_2_in;
         default: res = operand_1_in;
      endcase
   end

   always_comb begin
      flags             = '0;
      flags[FLAG_ZERO]  = (res == '0);
      flags[FLAG_CARRY] = carry;
      flags[FLAG_OVF]   = ovf;
   end

   // Decode result enters the delay line; the output register below
   // is the last of the LATENCY stages.
   logic          dl_in_valid;
   logic          dl_valid;
   logic [PW-1:0] dl_data;

   assign dl_in_valid = action_valid & ~rst;

   alu_delay_line #(
      .WIDTH (PW),
      .DEPTH (LATENCY - 1)
   ) u_delay (
      .clk       (clk),
      .clr       (rst),
      .in_valid  (dl_in_valid),
      .in_data   ({flags, res}),
      .out_valid (dl_valid),
      .out_data  (dl_data)
   );

   logic                  out_valid_q;
   logic                  out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [DATA_WIDTH-1:0] out_data_d;
   logic [FLAG_WIDTH-1:0] out_flags_q;
   logic [FLAG_WIDTH-1:0] out_flags_d;

   always_comb begin
      out_valid_d = dl_valid;
      out_data_d  = out_data_q;
      out_flags_d = out_flags_q;
      if (dl_valid) begin
         out_data_d  = dl_data[DATA_WIDTH-1:0];
         out_flags_d = dl_data[PW-1:DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_flags_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_flags_q <= out_flags_d;
      end
   end

   assign container_out       = out_data_q;
   assign container_out_valid = out_valid_q;
   assign flags_out           = out_flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus reset, burst and latency checks
// on three alu_pipe instances (LATENCY 1, 2, 5).
module tb_alu_pipe;

   localparam int W  = 48;
   localparam int AL = 64;
   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [55:0] FILL = 56'h5AC3F00FA53C69;

   logic          clk = 1'b0;
   logic          rst;
   logic [AL-1:0] action_in;
   logic          action_valid;
   logic [W-1:0]  op1;
   logic [W-1:0]  op2;

   logic [W-1:0] out1, out2, out5;
   logic         v1, v2, v5;
   logic [2:0]   f1, f2, f5;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_pipe #(.STAGE_ID(0), .ACTION_LEN(AL), .DATA_WIDTH(W),
              .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .action_in(action_in),
      .action_valid(action_valid), .operand_1_in(op1),
      .operand_2_in(op2), .container_out(out1),
      .container_out_valid(v1), .flags_out(f1));

   alu_pipe #(.STAGE_ID(1), .ACTION_LEN(AL), .DATA_WIDTH(W),
              .LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst), .action_in(action_in),
      .action_valid(action_valid), .operand_1_in(op1),
      .operand_2_in(op2), .container_out(out2),
      .container_out_valid(v2), .flags_out(f2));

   alu_pipe #(.STAGE_ID(2), .ACTION_LEN(AL), .DATA_WIDTH(W),
              .LATENCY(5)) u_l5 (
      .clk(clk), .rst(rst), .action_in(action_in),
      .action_valid(action_valid), .operand_1_in(op1),
      .operand_2_in(op2), .container_out(out5),
      .container_out_valid(v5), .flags_out(f5));

   typedef struct {
      logic [7:0]   opc;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [2:0]   fl;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] opc, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      action_in    = {opc, FILL};
      op1          = a;
      op2          = b;
      action_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      action_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   int first, last, got;
   int lat1, lat2, lat5;
   int s1, s2, s5;
   logic [W-1:0] bb_exp [4];

   initial begin
      // {opcode, op1, op2, result, {ovf,carry,zero}}
      vecs[0]  = '{8'h01, 48'd5, 48'd7, 48'd12, 3'b000};
`ifdef ALU_SAT_EN
      vecs[1]  = '{8'h02, 48'd3, 48'd5, 48'd0, 3'b011};
`else
      vecs[1]  = '{8'h02, 48'd3, 48'd5, 48'hFFFF_FFFF_FFFE, 3'b010};
`endif
      vecs[2]  = '{8'h01, 48'h7FFF_FFFF_FFFF, 48'd1,
                   48'h8000_0000_0000, 3'b100};
`ifdef ALU_SAT_EN
      vecs[3]  = '{8'h01, ONES, 48'd1, ONES, 3'b010};
`else
      vecs[3]  = '{8'h01, ONES, 48'd1, 48'd0, 3'b011};
`endif
      vecs[4]  = '{8'h03, 48'hF0F0, 48'hFF00, 48'hF000, 3'b000};
      vecs[5]  = '{8'h04, 48'h0F, 48'hF0, 48'hFF, 3'b000};
      vecs[6]  = '{8'h05, 48'hFF, 48'hFF, 48'd0, 3'b001};
      vecs[7]  = '{8'h06, 48'd1, 48'd47, 48'h8000_0000_0000, 3'b000};
      vecs[8]  = '{8'h06, 48'd1, 48'd48, 48'd0, 3'b001};
      vecs[9]  = '{8'h07, 48'h8000_0000_0000, 48'd47, 48'd1, 3'b000};
      vecs[10] = '{8'h07, ONES, 48'd63, 48'd0, 3'b001};
      vecs[11] = '{8'h0E, 48'd77, 48'h1234, 48'h1234, 3'b000};
      vecs[12] = '{8'h55, 48'd9, 48'd3, 48'd9, 3'b000};
      vecs[13] = '{8'h09, 48'd10, 48'd20, 48'd30, 3'b000};
      vecs[14] = '{8'h0A, 48'd20, 48'd20, 48'd0, 3'b001};
      vecs[15] = '{8'h02, 48'h8000_0000_0000, 48'd1,
                   48'h7FFF_FFFF_FFFF, 3'b100};
      vecs[16] = '{8'h06, 48'd1, 48'h104, 48'h10, 3'b000};

      rst = 1'b1;
      drive(8'h01, 48'd100, 48'd200);
      step(); step(); step();
      rst = 1'b0;
      action_valid = 1'b0;
      chk("rst_v2", v2, 0);
      chk("rst_out2", out2, 0);
      chk("rst_flg2", f2, 0);
      chk("rst_v5", v5, 0);
      chk("rst_out1", out1, 0);
      s1 = 0; s2 = 0; s5 = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         s1 += v1; s2 += v2; s5 += v5;
      end
      chk("rst_ignored_strobes", s1 + s2 + s5, 0);

      // table vectors on the LATENCY=2 instance
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].opc, vecs[i].a, vecs[i].b);
         step();
         action_valid = 1'b0;
         step();
         chk($sformatf("v%0d_vld", i), v2, 1);
         chk($sformatf("v%0d_res", i), out2, vecs[i].res);
         chk($sformatf("v%0d_flg", i), f2, vecs[i].fl);
         step();
         chk($sformatf("v%0d_vld_off", i), v2, 0);
         chk($sformatf("v%0d_hold", i), out2, vecs[i].res);
         chk($sformatf("v%0d_hold_flg", i), f2, vecs[i].fl);
      end
      idle(8);

      // back-to-back burst
      bb_exp[0] = 48'd12;
      bb_exp[1] = 48'hF0;
      bb_exp[2] = 48'h10;
      bb_exp[3] = 48'd9;
      first = -1; last = -1; got = 0;
      for (int c = 0; c < 14; c++) begin
         case (c)
            0: drive(8'h01, 48'd5, 48'd7);
            1: drive(8'h05, 48'hFF, 48'h0F);
            2: drive(8'h06, 48'd1, 48'd4);
            3: drive(8'h55, 48'd9, 48'd0);
            default: action_valid = 1'b0;
         endcase
         step();
         if (v2) begin
            if (got < 4) chk($sformatf("bb%0d_res", got), out2, bb_exp[got]);
            if (first < 0) first = c;
            last = c;
            got++;
         end
      end
      chk("bb_count", got, 4);
      chk("bb_first", first, 1);
      chk("bb_consecutive", last - first, 3);
      idle(8);

      // reset with two actions in flight
      drive(8'h01, 48'd1, 48'd1);
      step();
      drive(8'h01, 48'd2, 48'd2);
      step();
      action_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstA_v5", v5, 0);
      chk("rstA_out2", out2, 0);
      chk("rstA_out1", out1, 0);
      chk("rstA_flg5", f5, 0);
      s5 = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         s5 += v5;
      end
      chk("rstA_no_strobe5", s5, 0);
      chk("rstA_out5", out5, 0);

      // reset on the cycle right after an accept
      drive(8'h01, 48'd3, 48'd3);
      step();
      drive(8'h01, 48'd4, 48'd4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      action_valid = 1'b0;
      s2 = 0; s5 = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         s2 += v2; s5 += v5;
      end
      chk("rstB_no_strobe2", s2, 0);
      chk("rstB_no_strobe5", s5, 0);
      chk("rstB_out2", out2, 0);
      chk("rstB_out5", out5, 0);
      chk("rstB_out1", out1, 0);

      // latency sweep and hold on all instances
      lat1 = -1; lat2 = -1; lat5 = -1;
      s1 = 0; s2 = 0; s5 = 0;
      drive(8'h01, 48'd5, 48'd7);
      for (int k = 1; k <= 12; k++) begin
         step();
         action_valid = 1'b0;
         if (v1) begin s1++; if (lat1 < 0) lat1 = k; end
         if (v2) begin s2++; if (lat2 < 0) lat2 = k; end
         if (v5) begin s5++; if (lat5 < 0) lat5 = k; end
      end
      chk("lat1", lat1, 1);
      chk("lat2", lat2, 2);
      chk("lat5", lat5, 5);
      chk("strobes", s1 * 100 + s2 * 10 + s5, 111);
      chk("hold1", out1, 12);
      chk("hold2", out2, 12);
      chk("hold5", out5, 12);
      chk("hold5_flg", f5, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
